wr_req_xbar_nxm: RTL and testbench

WR_REQ_XBAR_NXM -- requirements
Module: wr_req_xbar_nxm

---
 rtl/wr_req_xbar_nxm.sv | 164 ++++++++++++++++
 tb/tb_wr_req_xbar_nxm.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wr_req_xbar_nxm.sv
// wr_req_xbar_nxm
//   Routes write requests from IN_NUM input ports to OUT_NUM output channels.
//   The destination channel is taken from the address field
//   wr_addr[i][SEL_LSB +: $clog2(OUT_NUM)]. Each output has a round-robin
//   arbiter and a one-entry output register that holds the winning request.
//   An output takes a request only when it is offered a free data-buffer
//   entry (alloc_vld). That entry index travels with the request as
//   sel_wr_db_id.
//
// Handshake: a transfer happens on a rising edge where valid && ready.
//   Input side: wr_cmd_vld / wr_cmd_rdy. wr_cmd_rdy is combinational and is
//   high only in the cycle the input wins arbitration.
//   Alloc side: alloc_vld / alloc_rdy. alloc_rdy equals the grant of that output.
//   Output side: sel_wr_vld / sel_wr_rdy. Once sel_wr_vld is high, it and all
//   sel_wr_* fields hold until sel_wr_rdy is seen.
//
// Ports
//   clk, rst_n                 clock, async active-low reset
//   wr_cmd_vld/rdy, wr_addr, wr_data, wr_strb, wr_cmd_txnid, wr_sideband
//                              per-input request (packed [IN_NUM][W])
//   alloc_vld/rdy, alloc_idx   per-output free data-buffer entry offer
//   sel_wr_*                   per-output registered request
module wr_req_xbar_nxm #(
    parameter int IN_NUM  = 8,
    parameter int OUT_NUM = 4,
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 1024,
    parameter int STRB_W  = DATA_W / 8,
    parameter int TXNID_W = 8,
    parameter int SB_W    = 16,
    parameter int DBID_W  = 6,
    parameter int SEL_LSB = ADDR_W - $clog2(OUT_NUM),
    localparam int SW     = $clog2(OUT_NUM),
    localparam int SRC_W  = (IN_NUM > 1) ? $clog2(IN_NUM) : 1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [IN_NUM-1:0]                 wr_cmd_vld,
    output logic [IN_NUM-1:0]                 wr_cmd_rdy,
    input  logic [IN_NUM-1:0][ADDR_W-1:0]     wr_addr,
    input  logic [IN_NUM-1:0][DATA_W-1:0]     wr_data,
    input  logic [IN_NUM-1:0][STRB_W-1:0]     wr_strb,
    input  logic [IN_NUM-1:0][TXNID_W-1:0]    wr_cmd_txnid,
    input  logic [IN_NUM-1:0][SB_W-1:0]       wr_sideband,
    input  logic [OUT_NUM-1:0]                alloc_vld,
    input  logic [OUT_NUM-1:0][DBID_W-1:0]    alloc_idx,
    output logic [OUT_NUM-1:0]                alloc_rdy,
    output logic [OUT_NUM-1:0]                sel_wr_vld,
    input  logic [OUT_NUM-1:0]                sel_wr_rdy,
    output logic [OUT_NUM-1:0][ADDR_W-1:0]    sel_wr_addr,
    output logic [OUT_NUM-1:0][DATA_W-1:0]    sel_wr_data,
    output logic [OUT_NUM-1:0][STRB_W-1:0]    sel_wr_strb,
    output logic [OUT_NUM-1:0][TXNID_W-1:0]   sel_wr_txnid,
    output logic [OUT_NUM-1:0][SB_W-1:0]      sel_wr_sideband,
    output logic [OUT_NUM-1:0][DBID_W-1:0]    sel_wr_db_id,
    output logic [OUT_NUM-1:0][SRC_W-1:0]     sel_wr_src
);

    logic [IN_NUM-1:0][SW-1:0]       dest;
    logic [OUT_NUM-1:0]              gnt_vld;
    logic [OUT_NUM-1:0][SRC_W-1:0]   gnt_idx;
    logic [OUT_NUM-1:0]              vld_q, vld_d;
    logic [OUT_NUM-1:0][SRC_W-1:0]   ptr_q, ptr_d;

    logic [OUT_NUM-1:0][ADDR_W-1:0]  addr_q;
    logic [OUT_NUM-1:0][DATA_W-1:0]  data_q;
    logic [OUT_NUM-1:0][STRB_W-1:0]  strb_q;
    logic [OUT_NUM-1:0][TXNID_W-1:0] txnid_q;
    logic [OUT_NUM-1:0][SB_W-1:0]    sb_q;
    logic [OUT_NUM-1:0][DBID_W-1:0]  dbid_q;
    logic [OUT_NUM-1:0][SRC_W-1:0]   src_q;

    always_comb begin
        for (int i = 0; i < IN_NUM; i++) begin
            dest[i] = wr_addr[i][SEL_LSB +: SW];
        end
    end

    // Round-robin arbitration per output. The search starts at ptr_q[o] and
    // wraps at IN_NUM, so IN_NUM does not have to be a power of two.
    // Grants are forced off while rst_n is low, so nothing is accepted
    // before the first edge after reset release. The output register is free
    // when it is empty or is draining this cycle. That is the only path from
    // sel_wr_rdy into the grant logic.
    always_comb begin
        int               idx_int;
        logic [SRC_W-1:0] idx;
        gnt_vld    = '0;
        gnt_idx    = '0;
        wr_cmd_rdy = '0;
        idx_int    = 0;
        idx        = '0;
        for (int o = 0; o < OUT_NUM; o++) begin
            if (rst_n && alloc_vld[o] && (!vld_q[o] || sel_wr_rdy[o])) begin
                for (int k = 0; k < IN_NUM; k++) begin
                    idx_int = int'(ptr_q[o]) + k;
                    if (idx_int >= IN_NUM) begin
                        idx_int = idx_int - IN_NUM;
                    end
                    idx = SRC_W'(idx_int);
                    if (!gnt_vld[o] && wr_cmd_vld[idx] && (dest[idx] == SW'(o))) begin
                        gnt_vld[o]      = 1'b1;
                        gnt_idx[o]      = idx;
                        wr_cmd_rdy[idx] = 1'b1;
                    end
                end
            end
        end
    end

    assign alloc_rdy = gnt_vld;

    always_comb begin
        vld_d = vld_q;
        ptr_d = ptr_q;
        for (int o = 0; o < OUT_NUM; o++) begin
            if (gnt_vld[o]) begin
                vld_d[o] = 1'b1;
                if (gnt_idx[o] == SRC_W'(IN_NUM - 1)) begin
                    ptr_d[o] = '0;
                end else begin
                    ptr_d[o] = gnt_idx[o] + 1'b1;
                end
            end else if (sel_wr_rdy[o]) begin
                vld_d[o] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            ptr_q <= '0;
        end else begin
            vld_q <= vld_d;
            ptr_q <= ptr_d;
        end
    end

    // Payload is qualified by vld_q, so it needs no reset.
    always_ff @(posedge clk) begin
        for (int o = 0; o < OUT_NUM; o++) begin
            if (gnt_vld[o]) begin
                addr_q[o]  <= wr_addr[gnt_idx[o]];
                data_q[o]  <= wr_data[gnt_idx[o]];
                strb_q[o]  <= wr_strb[gnt_idx[o]];
                txnid_q[o] <= wr_cmd_txnid[gnt_idx[o]];
                sb_q[o]    <= wr_sideband[gnt_idx[o]];
                dbid_q[o]  <= alloc_idx[o];
                src_q[o]   <= gnt_idx[o];
            end
        end
    end

    assign sel_wr_vld      = vld_q;
    assign sel_wr_addr     = addr_q;
    assign sel_wr_data     = data_q;
    assign sel_wr_strb     = strb_q;
    assign sel_wr_txnid    = txnid_q;
    assign sel_wr_sideband = sb_q;
    assign sel_wr_db_id    = dbid_q;
    assign sel_wr_src      = src_q;

endmodule

// File: tb/tb_wr_req_xbar_nxm.sv
module tb_wr_req_xbar_nxm;
  localparam int IN_NUM = 8;
  localparam int OUT_NUM = 4;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  typedef struct packed {
    logic [2:0]        src;
    logic [5:0]        db;
    logic [7:0]        txnid;
    logic [15:0]       sb;
    logic [STRB_W-1:0] strb;
    logic [63:0]       addr;
    logic [DATA_W-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [IN_NUM-1:0]               wr_cmd_vld;
  logic [IN_NUM-1:0]               wr_cmd_rdy;
  logic [IN_NUM-1:0][63:0]         wr_addr;
  logic [IN_NUM-1:0][DATA_W-1:0]   wr_data;
  logic [IN_NUM-1:0][STRB_W-1:0]   wr_strb;
  logic [IN_NUM-1:0][7:0]          wr_cmd_txnid;
  logic [IN_NUM-1:0][15:0]         wr_sideband;
  logic [OUT_NUM-1:0]              alloc_vld;
  logic [OUT_NUM-1:0][5:0]         alloc_idx;
  logic [OUT_NUM-1:0]              alloc_rdy;
  logic [OUT_NUM-1:0]              sel_wr_vld;
  logic [OUT_NUM-1:0]              sel_wr_rdy;
  logic [OUT_NUM-1:0][63:0]        sel_wr_addr;
  logic [OUT_NUM-1:0][DATA_W-1:0]  sel_wr_data;
  logic [OUT_NUM-1:0][STRB_W-1:0]  sel_wr_strb;
  logic [OUT_NUM-1:0][7:0]         sel_wr_txnid;
  logic [OUT_NUM-1:0][15:0]        sel_wr_sideband;
  logic [OUT_NUM-1:0][5:0]         sel_wr_db_id;
  logic [OUT_NUM-1:0][2:0]         sel_wr_src;

  int n_total = 0;
  int n_pass = 0;
  exp_t exp_q[OUT_NUM][$];

  wr_req_xbar_nxm #(.DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_cmd_vld(wr_cmd_vld), .wr_cmd_rdy(wr_cmd_rdy),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb),
    .wr_cmd_txnid(wr_cmd_txnid), .wr_sideband(wr_sideband),
    .alloc_vld(alloc_vld), .alloc_idx(alloc_idx), .alloc_rdy(alloc_rdy),
    .sel_wr_vld(sel_wr_vld), .sel_wr_rdy(sel_wr_rdy),
    .sel_wr_addr(sel_wr_addr), .sel_wr_data(sel_wr_data),
    .sel_wr_strb(sel_wr_strb), .sel_wr_txnid(sel_wr_txnid),
    .sel_wr_sideband(sel_wr_sideband), .sel_wr_db_id(sel_wr_db_id),
    .sel_wr_src(sel_wr_src)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard: every accepted output beat must match the oldest expected entry
  always @(negedge clk) begin
    if (rst_n) begin
      n_total++;
      if ((wr_cmd_rdy & ~wr_cmd_vld) !== '0)
        $display("FAIL rdy_without_vld: rdy=%b vld=%b", wr_cmd_rdy, wr_cmd_vld);
      else
        n_pass++;
      for (int o = 0; o < OUT_NUM; o++) begin
        if (sel_wr_vld[o] && sel_wr_rdy[o]) begin
          exp_t e;
          exp_t got;
          got = {sel_wr_src[o], sel_wr_db_id[o], sel_wr_txnid[o], sel_wr_sideband[o],
                 sel_wr_strb[o], sel_wr_addr[o], sel_wr_data[o]};
          n_total++;
          if (exp_q[o].size() == 0) begin
            $display("FAIL sb_unexpected out%0d: got %h, expected nothing", o, got);
          end else begin
            e = exp_q[o].pop_front();
            if (got !== e)
              $display("FAIL sb_beat out%0d: got %h, expected %h", o, got, e);
            else
              n_pass++;
          end
        end
      end
    end
  end

  // driver tasks
  task automatic drive_req(input int i, input int d, input logic [5:0] db,
                           input bit push, output exp_t e);
    e.src   = 3'(i);
    e.db    = db;
    e.txnid = 8'($urandom_range(0, 255));
    e.sb    = 16'($urandom_range(0, 65535));
    e.strb  = STRB_W'($urandom_range(0, 15));
    e.addr  = {2'(d), 30'($urandom), 32'($urandom)};
    e.data  = $urandom;
    wr_cmd_vld[i]   = 1'b1;
    wr_addr[i]      = e.addr;
    wr_data[i]      = e.data;
    wr_strb[i]      = e.strb;
    wr_cmd_txnid[i] = e.txnid;
    wr_sideband[i]  = e.sb;
    if (push) exp_q[d].push_back(e);
  endtask

  // call right after a negedge sample: finish the cycle, drop granted valids
  task automatic adv();
    logic [IN_NUM-1:0] g;
    g = wr_cmd_rdy;
    @(posedge clk);
    #1;
    wr_cmd_vld = wr_cmd_vld & ~g;
  endtask

  task automatic test_reset();
    exp_t e;
    alloc_vld = '1;
    drive_req(0, 0, 6'd0, 1'b0, e);
    @(negedge clk);
    n_total++;
    if (sel_wr_vld !== 4'b0) $display("FAIL reset_vld: got %b, expected 0000", sel_wr_vld);
    else n_pass++;
    n_total++;
    if (wr_cmd_rdy !== 8'b0) $display("FAIL reset_cmd_rdy: got %b, expected 0", wr_cmd_rdy);
    else n_pass++;
    n_total++;
    if (alloc_rdy !== 4'b0) $display("FAIL reset_alloc_rdy: got %b, expected 0000", alloc_rdy);
    else n_pass++;
    wr_cmd_vld = '0;
    alloc_vld = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_rr();
    int seq[3] = '{0, 3, 5};
    logic [5:0] db;
    exp_t e;
    db = 6'($urandom_range(0, 63));
    alloc_vld = 4'b0100;
    alloc_idx[2] = db;
    sel_wr_rdy = '1;
    for (int k = 0; k < 3; k++) drive_req(seq[k], 2, db, 1'b1, e);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_total++;
      if (wr_cmd_rdy !== 8'(1 << seq[k]))
        $display("FAIL rr_grant%0d: got %b, expected %b", k, wr_cmd_rdy, 8'(1 << seq[k]));
      else n_pass++;
      n_total++;
      if (alloc_rdy !== 4'b0100) $display("FAIL rr_alloc_rdy%0d: got %b, expected 0100", k, alloc_rdy);
      else n_pass++;
      adv();
    end
    @(negedge clk);
    n_total++;
    if (alloc_rdy !== 4'b0) $display("FAIL rr_idle_alloc: got %b, expected 0000", alloc_rdy);
    else n_pass++;
    adv();
    alloc_vld = '0;
  endtask

  task automatic test_alloc_stall();
    logic [5:0] db;
    exp_t e;
    db = 6'($urandom_range(0, 63));
    alloc_vld = '0;
    drive_req(1, 1, db, 1'b1, e);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_total++;
      if (wr_cmd_rdy[1] !== 1'b0) $display("FAIL stall_rdy%0d: got %b, expected 0", c, wr_cmd_rdy[1]);
      else n_pass++;
      adv();
    end
    alloc_vld[1] = 1'b1;
    alloc_idx[1] = db;
    @(negedge clk);
    n_total++;
    if ({wr_cmd_rdy[1], alloc_rdy[1]} !== 2'b11)
      $display("FAIL stall_grant: got rdy=%b alloc_rdy=%b, expected 1 1", wr_cmd_rdy[1], alloc_rdy[1]);
    else n_pass++;
    adv();
    alloc_vld = '0;
    @(negedge clk);
    adv();
  endtask

  task automatic test_back_to_back();
    logic [5:0] db0, db1;
    exp_t e0, e1;
    db0 = 6'($urandom_range(0, 31));
    db1 = 6'($urandom_range(32, 63));
    sel_wr_rdy = 4'b1110;
    alloc_vld = 4'b0001;
    alloc_idx[0] = db0;
    drive_req(2, 0, db0, 1'b1, e0);
    @(negedge clk);
    n_total++;
    if (wr_cmd_rdy !== 8'b0000_0100) $display("FAIL bp_first_grant: got %b, expected 00000100", wr_cmd_rdy);
    else n_pass++;
    adv();
    alloc_idx[0] = db1;
    drive_req(4, 0, db1, 1'b1, e1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_total++;
      if ({sel_wr_vld[0], sel_wr_src[0], sel_wr_db_id[0], sel_wr_addr[0], sel_wr_data[0]} !==
          {1'b1, e0.src, e0.db, e0.addr, e0.data})
        $display("FAIL bp_hold%0d: got vld=%b src=%0d db=%0d data=%h, expected 1 %0d %0d %h", c,
                 sel_wr_vld[0], sel_wr_src[0], sel_wr_db_id[0], sel_wr_data[0], e0.src, e0.db, e0.data);
      else n_pass++;
      n_total++;
      if ({wr_cmd_rdy[4], alloc_rdy[0]} !== 2'b00)
        $display("FAIL bp_no_grant%0d: got rdy=%b alloc_rdy=%b, expected 0 0", c, wr_cmd_rdy[4], alloc_rdy[0]);
      else n_pass++;
      adv();
    end
    sel_wr_rdy = '1;
    @(negedge clk);
    n_total++;
    if ({wr_cmd_rdy, alloc_rdy[0]} !== {8'b0001_0000, 1'b1})
      $display("FAIL b2b_grant: got rdy=%b alloc_rdy=%b, expected 00010000 1", wr_cmd_rdy, alloc_rdy[0]);
    else n_pass++;
    adv();
    alloc_vld = '0;
    @(negedge clk);
    adv();
  endtask

  task automatic test_parallel();
    logic [5:0] db;
    exp_t e;
    alloc_vld = '1;
    sel_wr_rdy = '1;
    for (int o = 0; o < 4; o++) begin
      db = 6'($urandom_range(0, 63));
      alloc_idx[o] = db;
      drive_req(o, o, db, 1'b1, e);
    end
    @(negedge clk);
    n_total++;
    if ({wr_cmd_rdy, alloc_rdy} !== {8'h0f, 4'hf})
      $display("FAIL par_grant: got rdy=%b alloc_rdy=%b, expected 00001111 1111", wr_cmd_rdy, alloc_rdy);
    else n_pass++;
    adv();
    alloc_vld = '0;
    @(negedge clk);
    n_total++;
    if (sel_wr_vld !== 4'hf) $display("FAIL par_valid: got %b, expected 1111", sel_wr_vld);
    else n_pass++;
    adv();
  endtask

  task automatic test_order();
    logic [5:0] db;
    logic got;
    exp_t e;
    alloc_vld = 4'b1000;
    for (int n = 0; n < 4; n++) begin
      db = 6'($urandom_range(0, 63));
      alloc_idx[3] = db;
      drive_req(6, 3, db, 1'b1, e);
      got = 1'b0;
      for (int c = 0; c < 40 && !got; c++) begin
        @(negedge clk);
        got = wr_cmd_rdy[6];
        adv();
        sel_wr_rdy[3] = 1'($urandom_range(0, 1));
      end
      n_total++;
      if (!got) $display("FAIL order_grant%0d: got no grant in 40 cycles, expected a grant", n);
      else n_pass++;
    end
    alloc_vld = '0;
    wr_cmd_vld = '0;
    sel_wr_rdy = '1;
    repeat (3) begin
      @(negedge clk);
      adv();
    end
  endtask

  task automatic test_reset_midflight();
    logic [5:0] db;
    exp_t e;
    alloc_vld = '1;
    sel_wr_rdy = '0;
    for (int o = 0; o < 4; o++) drive_req(o, o, 6'd0, 1'b0, e);
    @(negedge clk);
    adv();
    @(negedge clk);
    n_total++;
    if (sel_wr_vld !== 4'hf) $display("FAIL mid_full: got %b, expected 1111", sel_wr_vld);
    else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_total++;
    if (sel_wr_vld !== 4'h0) $display("FAIL mid_reset_vld: got %b, expected 0000", sel_wr_vld);
    else n_pass++;
    db = 6'($urandom_range(0, 63));
    alloc_idx[0] = db;
    alloc_vld = 4'b0001;
    sel_wr_rdy = '1;
    for (int i = 0; i < 3; i++) drive_req(i, 0, db, 1'b1, e);
    @(negedge clk);
    n_total++;
    if ({wr_cmd_rdy, alloc_rdy} !== 12'h0)
      $display("FAIL mid_reset_rdy: got rdy=%b alloc_rdy=%b, expected 0 0", wr_cmd_rdy, alloc_rdy);
    else n_pass++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_total++;
      if (wr_cmd_rdy !== 8'(1 << k))
        $display("FAIL mid_rr%0d: got %b, expected %b", k, wr_cmd_rdy, 8'(1 << k));
      else n_pass++;
      adv();
    end
    alloc_vld = '0;
    repeat (2) begin
      @(negedge clk);
      adv();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    wr_cmd_vld = '0;
    wr_addr = '0;
    wr_data = '0;
    wr_strb = '0;
    wr_cmd_txnid = '0;
    wr_sideband = '0;
    alloc_vld = '0;
    alloc_idx = '0;
    sel_wr_rdy = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_rr();
    test_alloc_stall();
    test_back_to_back();
    test_parallel();
    test_order();
    test_reset_midflight();
    repeat (3) begin
      @(negedge clk);
      adv();
    end
    for (int o = 0; o < OUT_NUM; o++) begin
      n_total++;
      if (exp_q[o].size() != 0)
        $display("FAIL sb_leftover out%0d: got %0d pending, expected 0", o, exp_q[o].size());
      else n_pass++;
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
